// File: rtl/dmem_responder.sv
// dmem_responder: ME-stage data memory with fixed access latency, byte-lane store merge
// and read-before-write response. Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses.
module dmem_responder #(
  parameter int unsigned DEPTH_W = 1024,
  parameter int unsigned LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        addr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_W);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [5:0]         op_q;
  logic [IDX_W+1:0]   addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [31:0]        mem_q [DEPTH_W];

  logic [5:0]         op_e;
  logic [IDX_W+1:0]   addr_e;
  logic [31:0]        wdata_e;
  logic               accept;
  logic               commit;
  logic               misal;
  logic [3:0]         be;
  logic [31:0]        wdata_lanes;
  logic [IDX_W-1:0]   idx;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:IDX_W+2];

  // With LAT=0 the commit happens straight from IDLE, so the live inputs stand in for the capture regs.
  always_comb begin
    accept = (state_q == ST_IDLE) && req;
    if (accept) begin
      op_e    = op;
      addr_e  = addr[IDX_W+1:0];
      wdata_e = wdata;
    end else begin
      op_e    = op_q;
      addr_e  = addr_q;
      wdata_e = wdata_q;
    end
    commit = (accept && (LAT == 0)) || ((state_q == ST_WAIT) && (cnt_q == 4'd1));
    idx    = addr_e[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    misal = ((op_e inside {OP_LH, OP_LHU, OP_SH}) && addr_e[0]) ||
            ((op_e inside {OP_LW, OP_SW}) && (addr_e[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif

    be          = '0;
    wdata_lanes = wdata_e;
    case (op_e)
      OP_SB: begin
        be          = 4'b0001 << addr_e[1:0];
        wdata_lanes = {4{wdata_e[7:0]}};
      end
      OP_SH: begin
        be          = addr_e[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_e[15:0]}};
      end
      OP_SW:   be = 4'b1111;
      default: be = '0;
    endcase
    if (misal) be = '0;
  end

  always_comb begin
    case (state_q)
      ST_IDLE: stall = req;
      ST_WAIT: stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            cnt_q   <= 4'(LAT);
            state_q <= (LAT == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (commit) rdata_q <= misal ? '0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op;
      addr_q  <= addr[IDX_W+1:0];
      wdata_q <= wdata;
    end
  end

  // Array is deliberately outside the reset; a reset only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (rst && commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  logic addr_err_q;
  always_ff @(posedge clk) begin
    if (!rst)        addr_err_q <= 1'b0;
    else if (commit) addr_err_q <= misal;
  end
  assign addr_err = addr_err_q;
`else
  assign addr_err = 1'b0;
`endif

endmodule
